// File: rtl/cnt169_pkg.sv
// cnt169_pkg: shared types and constants for the cnt169 sequencing controller
package cnt169_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

   localparam int CNT_W = 4;

   localparam logic [CNT_W-1:0] TERM_ONES = '1;
   localparam logic [CNT_W-1:0] TERM_ZERO = '0;

endpackage

// File: rtl/cnt169_term_det.sv
// cnt169_term_det: full-width terminal-count compare, all-ones when counting up, zero when counting down
module cnt169_term_det
   import cnt169_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic [W-1:0] count_i,
   input  logic         dir_i,
   output logic         term_hit_o
);

   // replicating dir yields all-ones for up and zero for down
   always_comb term_hit_o = (count_i == {W{dir_i}});

endmodule

// File: rtl/cnt169_seq.sv
// cnt169_seq: load/run/halt sequencer for a 74169-style counter; CNT169_AUTO_RELOAD_EN selects periodic reload instead of one-shot
module cnt169_seq
   import cnt169_pkg::*;
#(
   parameter int WIDTH = CNT_W
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] preset,
   input  logic             dir,
   input  logic [WIDTH-1:0] count_q,
   output logic [WIDTH-1:0] A,
   output logic             U_DB,
   output logic             ENPB,
   output logic             ENTB,
   output logic             LOADB,
   output logic             tick,
   output logic             busy,
   output logic             done
);

   state_e           state_q;
   logic [WIDTH-1:0] preset_q;
   logic             dir_q;
   logic             tick_q;
   logic             term_hit;

   cnt169_term_det #(.W(WIDTH)) u_term (
      .count_i    (count_q),
      .dir_i      (dir_q),
      .term_hit_o (term_hit)
   );

   // sequencer: stop beats start, start is only accepted from IDLE or DONE
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         preset_q <= WIDTH'(TERM_ZERO);
         dir_q    <= 1'b1;
         tick_q   <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         if (stop) state_q <= IDLE;
         else case (state_q)
            IDLE, DONE: if (start) begin
               preset_q <= preset;
               dir_q    <= dir;
               state_q  <= LOAD;
            end
            LOAD: state_q <= RUN;
            RUN: if (term_hit) begin
               tick_q <= 1'b1;
`ifdef CNT169_AUTO_RELOAD_EN
               state_q <= LOAD;
`else
               state_q <= DONE;
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // enables drop combinationally on the terminal value so the counter never wraps
   always_comb begin
      A     = preset_q;
      U_DB  = dir_q;
      LOADB = (state_q != LOAD);
      ENPB  = (state_q != RUN) || term_hit;
      ENTB  = ENPB;
      tick  = tick_q;
      busy  = (state_q == LOAD) || (state_q == RUN);
      done  = (state_q == DONE);
   end

endmodule

// File: tb/tb_cnt169_seq.sv
// tb_cnt169_seq: random + directed bench for cnt169_seq driving a 74169-style counter; honours CNT169_AUTO_RELOAD_EN
module tb_cnt169_seq;

`ifdef CNT169_AUTO_RELOAD_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST, start, stop, dir;
   logic [3:0] preset, cq, A;
   logic       U_DB, ENPB, ENTB, LOADB, tick, busy, done;

   int checks = 0;
   int errors = 0;

   int         ms;
   int         left;
   logic [3:0] mp, mq;
   bit         md, mtick;

   always #5 CLK = ~CLK;

   cnt169_seq dut (
      .CLK(CLK), .RST(RST), .start(start), .stop(stop), .preset(preset), .dir(dir),
      .count_q(cq), .A(A), .U_DB(U_DB), .ENPB(ENPB), .ENTB(ENTB), .LOADB(LOADB),
      .tick(tick), .busy(busy), .done(done)
   );

   // 74169 load: synchronous load, count when both enables low; bench-only clear on RST
   always_ff @(posedge CLK) begin
      if (RST) cq <= '0;
      else if (!LOADB) cq <= A;
      else if (!ENPB && !ENTB) cq <= U_DB ? cq + 4'd1 : cq - 4'd1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // behavioural model: 0 idle, 1 load, 2 run (left = cycles to terminal), 3 done
   task automatic model_edge(input bit st, input bit sp, input bit rs, input logic [3:0] pre, input bit dr);
      bit nt;
      nt = (ms == 2) && (left == 0) && !sp && !rs;
      if (rs) mq = 4'd0;
      else if (ms == 1) mq = mp;
      else if (ms == 2 && left != 0) mq = md ? mq + 4'd1 : mq - 4'd1;
      if (rs) begin
         ms = 0; mp = 4'd0; md = 1'b1;
      end else if (sp) ms = 0;
      else if (ms == 0 || ms == 3) begin
         if (st) begin mp = pre; md = dr; ms = 1; end
      end else if (ms == 1) begin
         ms = 2;
         left = md ? 15 - int'(mp) : int'(mp);
      end else if (left == 0) ms = AR ? 1 : 3;
      else left--;
      mtick = nt;
   endtask

   task automatic check_all();
      bit en_off;
      en_off = (ms != 2) || (left == 0);
      check("A", A, mp);
      check("U_DB", U_DB, md);
      check("LOADB", LOADB, ms != 1);
      check("ENPB", ENPB, en_off);
      check("ENTB", ENTB, en_off);
      check("tick", tick, mtick);
      check("busy", busy, ms == 1 || ms == 2);
      check("done", done, ms == 3);
      check("Q", cq, mq);
   endtask

   // one clock: inputs applied at negedge, model advanced at posedge, outputs checked at next negedge
   task automatic cyc(input bit st = 0, input bit sp = 0, input logic [3:0] pre = 4'h0,
                      input bit dr = 0, input bit rs = 0);
      start = st; stop = sp; preset = pre; dir = dr; RST = rs;
      @(posedge CLK);
      model_edge(st, sp, rs, pre, dr);
      @(negedge CLK);
      start = 0; stop = 0; RST = 0;
      check_all();
   endtask

   // cycles from the current one until tick is seen, bounded
   task automatic wait_tick(output int n);
      n = 1;
      while (!tick && n < 40) begin
         cyc();
         n++;
      end
      if (!tick) check("tick_timeout", 0, 1);
   endtask

   initial begin
      int n, t1;
      ms = 0; left = 0; mp = 0; mq = 0; md = 1; mtick = 0;
      start = 0; stop = 0; preset = 0; dir = 0; RST = 1;
      @(negedge CLK);
      cyc(0, 0, 4'h0, 0, 1);
      cyc(0, 0, 4'h0, 0, 1);
      check("rst_A", A, 0);
      check("rst_flags", {LOADB, ENPB, ENTB, U_DB, tick, busy, done}, 7'b1111000);

      cyc(1, 0, 4'hC, 1);
      check("load_low", LOADB, 0);
      wait_tick(n);
      check("up_C_latency", n, 6);
      check("up_C_Q", cq, 4'hF);
      cyc();
      check("up_C_done", done, !AR);
      cyc(0, 1);

      cyc(1, 0, 4'h3, 0);
      wait_tick(n);
      check("dn_3_latency", n, 6);
      if (AR) begin
         cyc();
         wait_tick(t1);
         check("dn_3_period", t1, 5);
      end
      cyc(0, 1);

      cyc(1, 0, 4'hF, 1);
      wait_tick(n);
      check("up_F_latency", n, 3);
      if (AR) begin
         cyc();
         wait_tick(t1);
         check("up_F_period", t1, 2);
         check("up_F_nowrap", cq, 4'hF);
      end
      cyc(0, 1);

      cyc(1, 0, 4'hE, 1);
      cyc();
      cyc();
      check("term_cycle_en", ENPB, 1);
      cyc(0, 1);
      check("stop_term_tick", tick, 0);
      check("stop_term_idle", busy, 0);
      check("stop_term_Q", cq, 4'hF);

      cyc(1, 1, 4'h5, 0);
      check("start_stop_idle", {busy, LOADB}, 2'b01);

      cyc(1, 0, 4'h8, 1);
      cyc();
      cyc(1, 0, 4'h2, 0);
      check("busy_start_A", A, 4'h8);
      wait_tick(n);
      check("busy_start_Q", cq, 4'hF);
      cyc(0, 1);

      cyc(1, 0, 4'h1, 1);
      cyc();
      cyc();
      cyc(0, 0, 4'h0, 0, 1);
      check("rst_mid_A", A, 0);
      check("rst_mid_flags", {LOADB, ENPB, tick, busy, done}, 5'b11000);
      cyc();

      for (int i = 0; i < 3000; i++)
         cyc(($urandom % 6) == 0, ($urandom % 25) == 0, 4'($urandom), 1'($urandom),
             ($urandom % 300) == 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
